// File: rtl/product_accum_pkg.sv
// Shared types and default widths for the product accumulator slice.
// State encoding for the group FSM plus default product/accumulator widths.
package product_accum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int PROD_W_DEF = 32;
    localparam int ACC_W_DEF  = 40;

endpackage

// File: rtl/product_accumulator_if.sv
// Product stream in / group result out handshake bundle.
// master: product source + result consumer; slave: the accumulator.
interface product_accumulator_if #(
    parameter int PROD_W    = product_accum_pkg::PROD_W_DEF,
    parameter int ACC_W     = product_accum_pkg::ACC_W_DEF,
    parameter int NUM_TERMS = 16
);
    localparam int CNT_W = $clog2(NUM_TERMS + 1);

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_ovf
    );

endinterface

// File: rtl/product_accum_add.sv
// Combinational ACC_W adder with carry out; i_a/i_b in, o_sum/o_carry out.
// With PRODUCT_ACCUMULATOR_SATURATE_EN the sum clamps to all-ones on carry.
module product_accum_add
    import product_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_carry
);
    logic [ACC_W:0] w_full;

    always_comb begin
        w_full  = {1'b0, i_a} + {1'b0, i_b};
        o_carry = w_full[ACC_W];
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        // Once clamped, any further nonzero term carries again, so the
        // accumulator stays pinned for the rest of the group.
        o_sum = w_full[ACC_W] ? '1 : w_full[ACC_W-1:0];
`else
        o_sum = w_full[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums groups of up to NUM_TERMS unsigned products; registered result out.
// Ports: clk, rst_n (async low), clr (sync), bus (slave: in_*/out_*).
// Optional macro PRODUCT_ACCUMULATOR_SATURATE_EN: clamp instead of wrap.
module product_accumulator
    import product_accum_pkg::*;
#(
    parameter int PROD_W    = PROD_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int NUM_TERMS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    product_accumulator_if.slave  bus
);
    localparam int CNT_W = $clog2(NUM_TERMS + 1);

    state_t           r_state;
    state_t           w_next;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_ovf;
    logic             w_ovf;
    logic             w_in_ready;
    logic             w_xfer;
    logic [ACC_W-1:0] w_prod;
    logic [ACC_W-1:0] w_sum;
    logic             w_carry;

    assign w_prod    = ACC_W'(bus.in_prod);
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    product_accum_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .i_a     (r_acc),
        .i_b     (w_prod),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    always_comb begin
        w_next     = r_state;
        w_acc      = r_acc;
        w_cnt      = r_cnt;
        w_ovf      = r_ovf;
        w_in_ready = (r_state != HOLD);
        w_xfer     = bus.in_valid && w_in_ready;

        unique case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_acc  = w_prod;
                    w_cnt  = CNT_W'(1);
                    w_ovf  = 1'b0;
                    w_next = (bus.in_last || NUM_TERMS == 1) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (w_xfer) begin
                    w_acc  = w_sum;
                    w_cnt  = w_cnt_inc;
                    w_ovf  = r_ovf | w_carry;
                    w_next = (bus.in_last ||
                              w_cnt_inc == CNT_W'(NUM_TERMS)) ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase

        // Clear discards the group, including a coincident input transfer.
        if (clr) begin
            w_next = IDLE;
            w_acc  = '0;
            w_cnt  = '0;
            w_ovf  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_acc   <= w_acc;
            r_cnt   <= w_cnt;
            r_ovf   <= w_ovf;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == HOLD);
    assign bus.out_acc   = r_acc;
    assign bus.out_count = r_cnt;
    assign bus.out_ovf   = r_ovf;

endmodule
